mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port, synchronous-read word memory between the core's instruction-fetch port and its load/store port.
- Sits between the multi-cycle RV32I core and the program/data RAM.
- Sequences every access as grant, then one response cycle.
- Data accesses have priority; a starvation counter guarantees fetch progress.

Parameters:
- ADDR_W, 8, word-address width (memory depth is 2**ADDR_W words of 32 bits).
- STARVE_LIMIT, 4, maximum consecutive data grants while i_req is pending. 0 means pure fixed data priority.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous active-high reset.
- i_req  in  1  fetch request; i_addr is held stable until i_gnt.
- i_addr  in  32  fetch byte address.
- i_gnt  out  1  fetch request accepted this cycle.
- i_rvalid  out  1  fetch data valid.
- i_rdata  out  32  fetch data.
- d_req  in  1  load/store request; d_we, d_wmask, d_addr and d_wdata are held stable until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_wmask  in  4  byte enables for stores; bit k selects byte k.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  load data valid, or store acknowledge.
- d_rdata  out  32  load data; 0 on a store acknowledge.
- mem_en  out  1  memory access strobe.
- mem_we  out  4  per-byte write enables.
- mem_addr  out  ADDR_W  word address = addr[ADDR_W+1:2].
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid the cycle after mem_en.

Behaviour:
- States: IDLE and RESP, plus a registered owner bit, starve_cnt and registered op flags.
- IDLE with a request:
  - Assert exactly one gnt and mem_en combinationally in the same cycle.
  - Drive mem_addr, mem_we and mem_wdata from the granted requester.
  - Latch the owner and whether the access is a store; next state is RESP.
- IDLE with no request: all strobes are 0 and the state stays IDLE.
- RESP:
  - Assert the owner's rvalid for exactly one cycle.
  - Load or fetch: rdata = mem_rdata, passed through combinationally.
  - Store: rdata = 0.
  - Requests are never granted in RESP. Next state is IDLE.
- Throughput is one access per 2 cycles. Grant-to-rvalid latency is 1 cycle.
- Selection when both requests are present in IDLE:
  - Data wins, unless STARVE_LIMIT != 0 and starve_cnt == STARVE_LIMIT; then fetch wins.
- starve_cnt update:
  - Increments on a data grant while i_req = 1, saturating at STARVE_LIMIT.
  - Clears on any fetch grant.
  - Holds otherwise.
- mem_we = d_wmask on a store grant, else 0000. A store with wmask 0000 still issues mem_en and is acknowledged.
- Address bits [1:0] and bits above ADDR_W+1 are ignored.
- Reset:
  - State IDLE, starve_cnt 0, owner = fetch.
  - All gnt, rvalid and mem_* outputs read 0 while reset is high.
  - Reset during RESP drops the pending response; no rvalid is issued.
- Requests that drop before their gnt are simply not served.

Optional Feature:
- Macro MEM_ARB_ERR_EN adds output ports i_err and d_err (1 bit each), both valid with rvalid.
- With MEM_ARB_ERR_EN, an access is an error if addr[1:0] != 0 or any addr bit above ADDR_W+1 is set. An error access:
  - still receives gnt;
  - drives mem_en = 0 and mem_we = 0000;
  - next cycle asserts rvalid with err = 1 and rdata = 0.
- Without MEM_ARB_ERR_EN: no err ports exist, and bad addresses are truncated silently as above.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding (IDLE, RESP);
  - owner constants (OWN_FETCH, OWN_DATA);
  - word-address slice helper constants.
- One natural sub-module, mem_arb_sel: combinational winner selection from i_req, d_req and starve_cnt, plus the starve_cnt next-value logic.

Test Plan:
- Fetch only: i_req with i_addr = 0x8, mem word 2 = 0x00A00113 -> i_gnt in the same cycle, mem_addr = 2, i_rvalid next cycle with i_rdata = 0x00A00113, no grant in RESP.
- Simultaneous i_req and d_req load at 0x10, STARVE_LIMIT = 4 -> d_gnt first. Then, with both held continuously, data wins 4 times and the 5th grant goes to fetch.
- Store d_addr = 0x20, d_wdata = 0xDEADBEEF, d_wmask = 0011, then load 0x20 from a word that was 0x11223344 -> mem_we = 0011, d_rvalid with d_rdata = 0, then readback 0x1122BEEF.
- Reset asserted in the RESP cycle of a fetch -> no i_rvalid; first request after reset is granted and starve_cnt = 0.
- STARVE_LIMIT = 0 with continuous d_req -> fetch is never granted while d_req = 1.
- MEM_ARB_ERR_EN defined, d_addr = 0x22 load -> d_gnt, mem_en = 0, next cycle d_rvalid = 1, d_err = 1, d_rdata = 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    // The word address starts above the byte-offset bits.
    localparam int WA_LSB = 2;
    localparam int BO_W   = 2;

endpackage

// File: rtl/mem_arb_sel.sv
// Winner select between fetch and data, plus the starvation counter next value. Combinational, zero latency.
// Grants only while en is high. Data wins unless the counter is saturated and a fetch is waiting.
module mem_arb_sel #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic             en,
    input  logic             i_req,
    input  logic             d_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             gnt_fetch,
    output logic             gnt_data,
    output logic [CNT_W-1:0] starve_nxt
);
    import mem_arb_pkg::*;

    localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIMIT);

    logic fetch_force;

    always_comb begin
        fetch_force = (STARVE_LIMIT != 0) && (starve_cnt == LIM);
        gnt_data    = en && d_req && !(i_req && fetch_force);
        gnt_fetch   = en && i_req && !gnt_data;

        starve_nxt = starve_cnt;
        if (gnt_fetch) begin
            starve_nxt = '0;
        end else if (gnt_data && i_req && (starve_cnt != LIM)) begin
            starve_nxt = starve_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one sync-read RAM between fetch and load/store: grant cycle, then one response cycle (1-cycle latency).
// Requesters hold their request until gnt; nothing is granted during the response. Optional MEM_ARB_ERR_EN adds err outputs.
module mem_port_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_wmask,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
`ifdef MEM_ARB_ERR_EN
    ,
    output logic              i_err,
    output logic              d_err
`endif
);
    import mem_arb_pkg::*;

    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    state_t            state, state_nxt;
    logic              owner, is_store, err_q;
    logic [CNT_W-1:0]  starve_cnt, starve_nxt;
    logic              gnt_f, gnt_d, any_gnt, idle_act, resp_act, sel_err;
    logic [31:0]       sel_addr, resp_data;

    assign idle_act = (state == ST_IDLE) && !reset;
    assign resp_act = (state == ST_RESP) && !reset;
    assign any_gnt  = gnt_f || gnt_d;

    mem_arb_sel #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_sel (
        .en         (idle_act),
        .i_req      (i_req),
        .d_req      (d_req),
        .starve_cnt (starve_cnt),
        .gnt_fetch  (gnt_f),
        .gnt_data   (gnt_d),
        .starve_nxt (starve_nxt)
    );

    assign sel_addr = gnt_d ? d_addr : i_addr;

`ifdef MEM_ARB_ERR_EN
    assign sel_err = (sel_addr[BO_W-1:0] != '0) || (|sel_addr[31:ADDR_W+WA_LSB]);
`else
    // Byte-offset and out-of-range bits are dropped silently in this build.
    logic unused_addr;
    assign unused_addr = ^{sel_addr[BO_W-1:0], sel_addr[31:ADDR_W+WA_LSB]};
    assign sel_err     = 1'b0;
`endif

    always_comb begin
        i_gnt     = gnt_f;
        d_gnt     = gnt_d;
        mem_en    = any_gnt && !sel_err;
        mem_we    = (gnt_d && d_we && !sel_err) ? d_wmask : 4'b0000;
        mem_addr  = any_gnt ? sel_addr[WA_LSB +: ADDR_W] : '0;
        mem_wdata = (gnt_d && d_we) ? d_wdata : 32'h0;
        resp_data = (is_store || err_q) ? 32'h0 : mem_rdata;
        i_rvalid  = resp_act && (owner == OWN_FETCH);
        d_rvalid  = resp_act && (owner == OWN_DATA);
        i_rdata   = i_rvalid ? resp_data : 32'h0;
        d_rdata   = d_rvalid ? resp_data : 32'h0;
    end

`ifdef MEM_ARB_ERR_EN
    assign i_err = i_rvalid && err_q;
    assign d_err = d_rvalid && err_q;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (any_gnt) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state      <= ST_IDLE;
            owner      <= OWN_FETCH;
            is_store   <= 1'b0;
            err_q      <= 1'b0;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            if (any_gnt) begin
                owner    <= gnt_d ? OWN_DATA : OWN_FETCH;
                is_store <= gnt_d && d_we;
                err_q    <= sel_err;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench: directed accesses push expected responses, a negedge monitor pops them on rvalid.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, preload;
    logic        i_req, i_gnt, i_rvalid;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [3:0]  d_wmask;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic        z_i_req, z_i_gnt, z_i_rvalid, z_d_req, z_d_gnt, z_d_rvalid, z_mem_en;
    logic [31:0] z_i_rdata, z_d_rdata, z_mem_wdata;
    logic [3:0]  z_mem_we;
    logic [7:0]  z_mem_addr;
    logic [31:0] z_mem_rdata = 32'h0;
`ifdef MEM_ARB_ERR_EN
    logic        i_err, d_err, z_i_err, z_d_err;
`endif

    mem_port_arbiter #(.ADDR_W(8), .STARVE_LIMIT(4)) dut (
        .CLK(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_wmask(d_wmask), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef MEM_ARB_ERR_EN
        , .i_err(i_err), .d_err(d_err)
`endif
    );

    mem_port_arbiter #(.ADDR_W(8), .STARVE_LIMIT(0)) dut_z (
        .CLK(clk), .reset(reset),
        .i_req(z_i_req), .i_addr(32'h8), .i_gnt(z_i_gnt), .i_rvalid(z_i_rvalid), .i_rdata(z_i_rdata),
        .d_req(z_d_req), .d_we(1'b0), .d_wmask(4'h0), .d_addr(32'h10), .d_wdata(32'h0),
        .d_gnt(z_d_gnt), .d_rvalid(z_d_rvalid), .d_rdata(z_d_rdata),
        .mem_en(z_mem_en), .mem_we(z_mem_we), .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata),
        .mem_rdata(z_mem_rdata)
`ifdef MEM_ARB_ERR_EN
        , .i_err(z_i_err), .d_err(z_d_err)
`endif
    );

    // Synchronous-read RAM model with byte writes.
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < 256; k++) mem[k] <= 32'h0;
            mem[2]    <= 32'h00A00113;
            mem[4]    <= 32'hCAFE0010;
            mem[8]    <= 32'h11223344;
            mem_rdata <= 32'h0;
        end else if (mem_en) begin
            mem_rdata <= mem[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    typedef struct {
        logic        is_data;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && (i_rvalid || d_rvalid)) begin
            chk1("single_rvalid", i_rvalid && d_rvalid, 1'b0);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rvalid: got i=%b d=%b want none", i_rvalid, d_rvalid);
            end else begin
                e = sb.pop_front();
                chk1("rvalid_owner", d_rvalid, e.is_data);
                chk32("rdata", e.is_data ? d_rdata : i_rdata, e.rdata);
`ifdef MEM_ARB_ERR_EN
                chk1("err", e.is_data ? d_err : i_err, e.err);
`endif
            end
        end
    end

    task automatic issue(input logic is_data, input logic we, input logic [3:0] mask,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input logic exp_en, input logic [7:0] exp_maddr);
        int n = 0;
        if (is_data) begin
            d_req = 1'b1; d_we = we; d_wmask = mask; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        @(negedge clk);
        while (!(is_data ? d_gnt : i_gnt) && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (n >= 20) begin
            total++;
            bad++;
            $display("FAIL gnt_timeout: got no gnt in 20 cycles want gnt");
            i_req = 1'b0;
            d_req = 1'b0;
            return;
        end
        chk1("other_gnt", is_data ? i_gnt : d_gnt, 1'b0);
        chk1("mem_en", mem_en, exp_en);
        if (exp_en) chk32("mem_addr", 32'(mem_addr), 32'(exp_maddr));
        chk32("mem_we", 32'(mem_we), (is_data && we && exp_en) ? 32'(mask) : 32'h0);
        if (is_data && we && exp_en) chk32("mem_wdata", mem_wdata, wdata);
        sb.push_back('{is_data, exp_rdata, exp_err});
        @(posedge clk); #1;
        @(negedge clk);
        chk1("gnt_in_resp", i_gnt || d_gnt, 1'b0);
        @(posedge clk); #1;
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    // Both requesters held: fetch word 2 and load word 4; pat bit g = 1 means grant g goes to data.
    task automatic contend(input int ngrants, input logic [7:0] pat, input logic push_last);
        i_req = 1'b1; i_addr = 32'h8;
        d_req = 1'b1; d_we = 1'b0; d_wmask = 4'h0; d_addr = 32'h10; d_wdata = 32'h0;
        for (int g = 0; g < ngrants; g++) begin
            @(negedge clk);
            chk1("ct_d_gnt", d_gnt, pat[g]);
            chk1("ct_i_gnt", i_gnt, !pat[g]);
            if (g < ngrants - 1 || push_last)
                sb.push_back('{pat[g], pat[g] ? 32'hCAFE0010 : 32'h00A00113, 1'b0});
            @(posedge clk); #1;
            if (g < ngrants - 1) begin
                @(negedge clk);
                chk1("ct_resp_gnt", i_gnt || d_gnt, 1'b0);
                @(posedge clk); #1;
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        if (push_last) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int zcnt = 0;
        reset = 1'b1; preload = 1'b1;
        i_req = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_wmask = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
        z_i_req = 1'b0; z_d_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 preload = 1'b0;
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_wmask = 4'hF;
        @(negedge clk);
        chk1("rst_i_gnt", i_gnt, 1'b0);
        chk1("rst_d_gnt", d_gnt, 1'b0);
        chk1("rst_mem_en", mem_en, 1'b0);
        chk32("rst_mem_we", 32'(mem_we), 32'h0);
        chk1("rst_rvalid", i_rvalid || d_rvalid, 1'b0);
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wmask = 4'h0;
        reset = 1'b0;

        issue(1'b0, 1'b0, 4'h0, 32'h8, 32'h0, 32'h00A00113, 1'b0, 1'b1, 8'd2);
        contend(5, 8'h0F, 1'b1);

        issue(1'b1, 1'b1, 4'b0011, 32'h20, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 8'd8);
        issue(1'b1, 1'b0, 4'h0, 32'h20, 32'h0, 32'h1122BEEF, 1'b0, 1'b1, 8'd8);
        issue(1'b1, 1'b1, 4'b0000, 32'h20, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b1, 8'd8);
        issue(1'b1, 1'b0, 4'h0, 32'h20, 32'h0, 32'h1122BEEF, 1'b0, 1'b1, 8'd8);

        // Reset during the response of a fetch drops it; the held request is granted right after.
        i_req = 1'b1; i_addr = 32'h8;
        @(negedge clk);
        chk1("rf_gnt", i_gnt, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk1("rf_no_rvalid", i_rvalid, 1'b0);
        chk1("rf_no_gnt", i_gnt, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk1("rf_first_gnt", i_gnt, 1'b1);
        sb.push_back('{1'b0, 32'h00A00113, 1'b0});
        @(posedge clk); #1;
        i_req = 1'b0;
        @(posedge clk); #1;

        // Three data wins build the counter to 3; reset must clear it back to 0.
        contend(3, 8'h07, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk1("rs_no_rvalid", d_rvalid, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        contend(5, 8'h0F, 1'b1);

`ifdef MEM_ARB_ERR_EN
        issue(1'b1, 1'b0, 4'h0, 32'h22, 32'h0, 32'h0, 1'b1, 1'b0, 8'd8);
        issue(1'b1, 1'b1, 4'hF, 32'h400, 32'h12345678, 32'h0, 1'b1, 1'b0, 8'd0);
`else
        issue(1'b1, 1'b0, 4'h0, 32'h413, 32'h0, 32'hCAFE0010, 1'b0, 1'b1, 8'd4);
`endif

        z_i_req = 1'b1; z_d_req = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk1("z_no_fetch", z_i_gnt, 1'b0);
            if (z_d_gnt) zcnt++;
            @(posedge clk); #1;
        end
        z_i_req = 1'b0; z_d_req = 1'b0;
        chk32("z_data_grants", 32'(zcnt), 32'd10);

        repeat (3) @(posedge clk);
        chk32("sb_empty", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
